// File: rtl/context_loader_if.sv
// Configuration beat channel feeding the context loader.
// The master drives beats; the slave (loader) returns ready.
interface context_loader_if;
  logic [31:0] cfg_word;
  logic        cfg_valid;
  logic        cfg_last;
  logic        cfg_ready;

  modport master (output cfg_word, cfg_valid, cfg_last, input cfg_ready);
  modport slave  (input cfg_word, cfg_valid, cfg_last, output cfg_ready);
endinterface

// File: rtl/context_loader.sv
// Assembles 32-bit configuration beats into (width+1)-bit context words,
// writes them to the PE context cache and launches execution after the last one.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no program in progress; first accepted beat opens one
// ASSEMBLE | collecting beats of the current context word
// WRITE    | data_valid strobe for the completed word; beats stalled
// START    | one-cycle start pulse after the final context; beats stalled
// DRAIN    | context depth overflowed; discard beats up to cfg_last
module context_loader #(
  parameter int width = 120,
  parameter int DEPTH = 16
) (
  input  logic                       CLK,
  input  logic                       RST,
  context_loader_if.slave            cfg,
  output logic [width:0]             data,
  output logic                       data_valid,
  output logic                       start,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] ctx_count,
  output logic                       err
);

  localparam int BEATS  = (width + 32) / 32;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    ASSEMBLE,
    WRITE,
    START,
    DRAIN
  } state_t;

  state_t            state, state_nxt;
  logic [BEAT_W-1:0] beat_cnt;
  logic [width:0]    asm_buf, asm_nxt;
  logic              last_seen;
  logic              final_beat;
  logic              take_beat;
  logic              word_done;
  logic              set_err;

  assign final_beat = (beat_cnt == BEAT_W'(BEATS - 1));

  // Beat k lands in bits [32k+31:32k]; bits above width are simply dropped.
  always_comb begin
    asm_nxt = asm_buf;
    for (int i = 0; i <= width; i++) begin
      if (BEAT_W'(i / 32) == beat_cnt) asm_nxt[i] = cfg.cfg_word[i % 32];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    cfg.cfg_ready = 1'b0;
    data_valid    = 1'b0;
    start         = 1'b0;
    busy          = 1'b0;
    take_beat     = 1'b0;
    word_done     = 1'b0;
    set_err       = 1'b0;
    unique case (state)
      IDLE, ASSEMBLE: begin
        cfg.cfg_ready = 1'b1;
        busy          = (state == ASSEMBLE);
        take_beat     = cfg.cfg_valid;
        if (cfg.cfg_valid) begin
          if (final_beat) begin
            word_done = 1'b1;
            state_nxt = WRITE;
          end else if (cfg.cfg_last) begin
            set_err   = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = ASSEMBLE;
          end
        end
      end
      WRITE: begin
        data_valid = 1'b1;
        busy       = 1'b1;
        if (last_seen) begin
          state_nxt = START;
        end else if (ctx_count == CNT_W'(DEPTH)) begin
          set_err   = 1'b1;
          state_nxt = DRAIN;
        end else begin
          state_nxt = ASSEMBLE;
        end
      end
      START: begin
        start     = 1'b1;
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      DRAIN: begin
        cfg.cfg_ready = 1'b1;
        busy          = 1'b1;
        if (cfg.cfg_valid && cfg.cfg_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      beat_cnt  <= '0;
      asm_buf   <= '0;
      last_seen <= 1'b0;
      data      <= '0;
      ctx_count <= '0;
      err       <= 1'b0;
    end else begin
      if (take_beat) begin
        asm_buf  <= asm_nxt;
        beat_cnt <= (final_beat || cfg.cfg_last) ? '0 : beat_cnt + 1'b1;
      end
      if (word_done) begin
        data      <= asm_nxt;
        last_seen <= cfg.cfg_last;
      end
      // The opening beat of a program restarts the count (at 1 if it is already a full word).
      if (take_beat && state == IDLE) ctx_count <= word_done ? CNT_W'(1) : '0;
      else if (word_done)             ctx_count <= ctx_count + 1'b1;
      if (set_err) err <= 1'b1;
    end
  end

endmodule
